div_sequencer: RTL and testbench

//   Multi-cycle 32-bit integer divider and its controller for the MIPS datapath.

---
 rtl/div_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_div_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Takes one quotient bit per cycle, holds the pipeline while it works,
// and presents quotient (LO) / remainder (HI) with a one-cycle strobe.
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             valid,
  output logic             busy,
  output logic             stall
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PREP = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Index of the final RUN iteration; the counter starts at zero in PREP.
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;

  // Operands latched at acceptance; op_b is overwritten with |b| in PREP.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;

  // Working registers: prem is the partial remainder, dvd starts as |a|
  // and collects quotient bits in from the bottom as the dividend shifts out.
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] dvd;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             div_by_zero;
  logic             last_iter;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] prem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;

  // Acceptance only from IDLE, and an annul in the same cycle vetoes it.
  always_comb begin
    accept      = (state == IDLE) && start && !annul;
    div_by_zero = (b == '0);
    last_iter   = (cnt == LAST_ITER);
  end

  // Magnitudes for the signed case; -2^WIDTH-1 maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    abs_a = (op_signed && op_a[WIDTH-1]) ? (~op_a + WIDTH'(1)) : op_a;
    abs_b = (op_signed && op_b[WIDTH-1]) ? (~op_b + WIDTH'(1)) : op_b;
  end

  // One restoring step: shift in the next dividend bit, trial-subtract |b|,
  // keep the difference only if it did not go negative.
  always_comb begin
    shifted   = {prem, dvd[WIDTH-1]};
    diff      = shifted - {1'b0, op_b};
    qbit      = ~diff[WIDTH];
    prem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next  = {dvd[WIDTH-2:0], qbit};
    q_fin     = q_neg ? (~dvd_next + WIDTH'(1)) : dvd_next;
    r_fin     = r_neg ? (~prem_next + WIDTH'(1)) : prem_next;
  end

  // Next-state selection; annul pulls PREP/RUN straight back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = div_by_zero ? DONE : PREP;
        end
      end
      PREP: begin
        state_next = annul ? IDLE : RUN;
      end
      RUN: begin
        if (annul) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, sign preparation and the per-cycle divide step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      prem      <= '0;
      dvd       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a      <= a;
            op_b      <= b;
            op_signed <= is_signed;
          end
        end
        PREP: begin
          dvd   <= abs_a;
          op_b  <= abs_b;
          q_neg <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          r_neg <= op_signed && op_a[WIDTH-1];
          prem  <= '0;
          cnt   <= '0;
        end
        RUN: begin
          prem <= prem_next;
          dvd  <= dvd_next;
          cnt  <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Result registers only change when a result is produced, so an annulled
  // divide leaves the previous result visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
    end else if (accept && div_by_zero) begin
      quotient  <= '1;
      remainder <= a;
    end else if ((state == RUN) && !annul && last_iter) begin
      quotient  <= q_fin;
      remainder <= r_fin;
    end
  end

  // Handshake outputs; stall rises combinationally with an acceptable start.
  always_comb begin
    busy  = (state == PREP) || (state == RUN);
    valid = (state == DONE) && !annul;
    stall = busy || accept;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed and randomized checks of div_sequencer against
// an arithmetic reference model with a countdown-based timing model.
module tb_div_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             start;
  logic             is_signed;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             valid;
  logic             busy;
  logic             stall;

  int tests_run = 0;
  int tests_failed = 0;
  int vcount = 0;

  // Reference model state: cycles of busy left, a DONE flag, visible results.
  int               m_left;
  bit               m_done;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] m_r;
  logic [WIDTH-1:0] m_pend_q;
  logic [WIDTH-1:0] m_pend_r;

  div_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .annul(annul), .a(a), .b(b), .quotient(quotient),
    .remainder(remainder), .valid(valid), .busy(busy), .stall(stall)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Plain arithmetic reference: returns {remainder, quotient}.
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] x,
                                          input logic [31:0] y);
    longint nx, ny, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (s) begin
      nx = longint'($signed(x));
      ny = longint'($signed(y));
    end else begin
      nx = longint'({32'd0, x});
      ny = longint'({32'd0, y});
    end
    q = nx / ny;
    r = nx % ny;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input logic [31:0] av,
                               input logic [31:0] bv);
    @(posedge clk);
    #1;
    start = 1'b1;
    is_signed = s;
    a = av;
    b = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitValid(input string name, input int exp_lat,
                           input logic [31:0] eq, input logic [31:0] er);
    int n;
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (valid && !seen) begin
        seen = 1'b1;
        n = i;
        checkOutput({name, "_q"}, {32'd0, quotient}, {32'd0, eq});
        checkOutput({name, "_r"}, {32'd0, remainder}, {32'd0, er});
        break;
      end
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(exp_lat));
  endtask

  // Timing/result model stepped on the same edges the DUT samples inputs.
  always @(posedge clk or posedge rst) begin
    logic [63:0] res;
    if (rst) begin
      m_left = 0;
      m_done = 1'b0;
      m_q = '0;
      m_r = '0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      if (annul) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1'b1;
          m_q = m_pend_q;
          m_r = m_pend_r;
        end
      end
    end else if (start && !annul) begin
      res = ref_div(is_signed, a, b);
      if (b == '0) begin
        m_done = 1'b1;
        m_q = res[31:0];
        m_r = res[63:32];
      end else begin
        m_left = WIDTH + 1;
        m_pend_q = res[31:0];
        m_pend_r = res[63:32];
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit idle;
    idle = (m_left == 0) && !m_done;
    checkOutput("valid", {63'd0, valid}, {63'd0, m_done && !annul});
    checkOutput("busy", {63'd0, busy}, {63'd0, m_left > 0});
    checkOutput("stall", {63'd0, stall},
                {63'd0, (m_left > 0) || (start && idle && !annul)});
    checkOutput("quotient", {32'd0, quotient}, {32'd0, m_q});
    checkOutput("remainder", {32'd0, remainder}, {32'd0, m_r});
    if (valid) vcount++;
  end

  initial begin
    int v0;
    int pick;
    logic [31:0] pool [6];
    rst = 1'b1;
    start = 1'b0;
    is_signed = 1'b0;
    annul = 1'b0;
    a = '0;
    b = '0;

    checkOutput("model_pin_divu", ref_div(1'b0, 32'd100, 32'd7),
                {32'd2, 32'd14});
    checkOutput("model_pin_div", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),
                {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    checkOutput("model_pin_ovf", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF),
                {32'd0, 32'h8000_0000});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_q", {32'd0, quotient}, 64'd0);
    checkOutput("reset_flags", {61'd0, valid, busy, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 32'd100, 32'd7);
    waitValid("divu_100_7", 34, 32'd14, 32'd2);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
    waitValid("div_m7_2", 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    waitValid("div_ovf", 34, 32'h8000_0000, 32'd0);
    applyStimulus(1'b0, 32'd5, 32'd0);
    waitValid("divu_by_zero", 1, 32'hFFFF_FFFF, 32'd5);
    applyStimulus(1'b1, 32'hFFFF_FFF0, 32'd0);
    waitValid("div_by_zero", 1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);

    // Annul partway through RUN: no strobe, previous result stays.
    applyStimulus(1'b0, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk);
    #1;
    annul = 1'b0;
    v0 = vcount;
    repeat (40) @(posedge clk);
    checkOutput("annul_no_valid", 64'(vcount - v0), 64'd0);
    checkOutput("annul_hold_q", {32'd0, quotient}, {32'd0, 32'hFFFF_FFFF});
    checkOutput("annul_hold_r", {32'd0, remainder}, {32'd0, 32'hFFFF_FFF0});
    applyStimulus(1'b0, 32'd9, 32'd3);
    waitValid("divu_9_3", 34, 32'd3, 32'd0);

    // Start held high: accepted at E0 and E35 only, two strobes.
    @(posedge clk);
    #1;
    start = 1'b1;
    is_signed = 1'b0;
    a = 32'd77;
    b = 32'd10;
    v0 = vcount;
    repeat (69) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    checkOutput("held_start_valids", 64'(vcount - v0), 64'd2);

    // Asynchronous reset in the middle of RUN.
    applyStimulus(1'b0, 32'd123456, 32'd789);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_q", {32'd0, quotient}, 64'd0);
    checkOutput("midrun_reset_r", {32'd0, remainder}, 64'd0);
    checkOutput("midrun_reset_flags", {61'd0, valid, busy, stall}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    v0 = vcount;
    repeat (40) @(posedge clk);
    checkOutput("midrun_reset_no_valid", 64'(vcount - v0), 64'd0);

    $display("[TB] randomized traffic");
    pool[0] = 32'h0000_0000;
    pool[1] = 32'h8000_0000;
    pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h0000_0001;
    pool[4] = 32'h7FFF_FFFF;
    pool[5] = 32'hFFFF_FFFE;
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 2) == 0);
      annul = ($urandom_range(0, 39) == 0);
      is_signed = $urandom_range(0, 1) == 1;
      pick = $urandom_range(0, 9);
      a = (pick < 6) ? pool[pick] : $urandom();
      pick = $urandom_range(0, 9);
      if (pick < 6) b = pool[pick];
      else if (pick < 8) b = $urandom_range(1, 20);
      else b = $urandom();
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    annul = 1'b0;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
